// File: rtl/meikyuu_pkg.sv
// Shared definitions for the meikyuu video path.
//   vga_timing_t  : one complete raster timing set (porches, sync, polarity)
//   VGA_640x480   : 25 MHz-class 640x480@60 timing, active-low syncs
//   VGA_800x600   : 40 MHz-class 800x600@60 timing, active-high syncs
//   DEF_X_W/Y_W   : default coordinate widths (hold H_TOTAL-1 / V_TOTAL-1 for 640x480)
package meikyuu_pkg;

  typedef struct packed {
    int unsigned h_active;
    int unsigned h_fp;
    int unsigned h_sync;
    int unsigned h_bp;
    int unsigned v_active;
    int unsigned v_fp;
    int unsigned v_sync;
    int unsigned v_bp;
    bit          hs_pol;
    bit          vs_pol;
  } vga_timing_t;

  localparam vga_timing_t VGA_640x480 = '{
    h_active: 640, h_fp: 16, h_sync: 96,  h_bp: 48,
    v_active: 480, v_fp: 10, v_sync: 2,   v_bp: 33,
    hs_pol: 1'b0,  vs_pol: 1'b0
  };

  localparam vga_timing_t VGA_800x600 = '{
    h_active: 800, h_fp: 40, h_sync: 128, h_bp: 88,
    v_active: 600, v_fp: 1,  v_sync: 4,   v_bp: 23,
    hs_pol: 1'b1,  vs_pol: 1'b1
  };

  localparam int unsigned DEF_X_W = 10;
  localparam int unsigned DEF_Y_W = 10;

endpackage

// File: rtl/sync_delay.sv
// Pixel-rate shift register that lines sync/blank up with a pipelined renderer.
//   clk, rst_n : clock and async active-low reset
//   ce         : advance enable (one pulse per pixel)
//   din        : undelayed {hs, vs, blank_n}
//   dout       : din delayed by DEPTH ce pulses; DEPTH=0 is a straight wire
module sync_delay #(
  parameter int unsigned            DEPTH   = 0,
  parameter int unsigned            WIDTH   = 3,
  parameter logic [WIDTH-1:0]       RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ce,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  // At least one stage always exists so the port list stays fully used;
  // for DEPTH=0 the output simply bypasses it.
  localparam int unsigned NST = (DEPTH == 0) ? 1 : DEPTH;

  logic [WIDTH-1:0] stage [NST];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NST; i++) stage[i] <= RST_VAL;
    end else if (ce) begin
      stage[0] <= din;
      for (int unsigned i = 1; i < NST; i++) stage[i] <= stage[i-1];
    end
  end

  assign dout = (DEPTH == 0) ? din : stage[NST-1];

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator.
//   CLOCK_50    : system clock          reset_n     : async active-low reset
//   enable      : run timing; low freezes the raster and blanks the DAC
//   pix_ce      : one-CLOCK_50 pulse per pixel
//   x, y        : registered pixel column/row (loaded on pix_ce)
//   active      : x/y inside the visible window (undelayed)
//   line_start  : pix_ce pulse issuing h=0;  frame_start : pix_ce pulse issuing h=0,v=0
//   VGA_HS/VS/BLANK_N : sync/blank delayed by PIPE_LAT pixels
//   VGA_SYNC_N  : tied low            VGA_CLK : divided pixel clock to the DAC
// h_cnt/v_cnt name the pixel issued at the next pix_ce; x/y register it there.
module vga_timing_gen
  import meikyuu_pkg::*;
#(
  parameter int unsigned H_ACTIVE = VGA_640x480.h_active,
  parameter int unsigned H_FP     = VGA_640x480.h_fp,
  parameter int unsigned H_SYNC   = VGA_640x480.h_sync,
  parameter int unsigned H_BP     = VGA_640x480.h_bp,
  parameter int unsigned V_ACTIVE = VGA_640x480.v_active,
  parameter int unsigned V_FP     = VGA_640x480.v_fp,
  parameter int unsigned V_SYNC   = VGA_640x480.v_sync,
  parameter int unsigned V_BP     = VGA_640x480.v_bp,
  parameter bit          HS_POL   = VGA_640x480.hs_pol,
  parameter bit          VS_POL   = VGA_640x480.vs_pol,
  parameter int unsigned CLK_DIV  = 2,
  parameter int unsigned PIPE_LAT = 0,
  parameter int unsigned X_W      = DEF_X_W,
  parameter int unsigned Y_W      = DEF_Y_W
) (
  input  logic           CLOCK_50,
  input  logic           reset_n,
  input  logic           enable,
  output logic           pix_ce,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic           active,
  output logic           line_start,
  output logic           frame_start,
  output logic           VGA_HS,
  output logic           VGA_VS,
  output logic           VGA_BLANK_N,
  output logic           VGA_SYNC_N,
  output logic           VGA_CLK
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned DIV_W   = $clog2(CLK_DIV);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);
  localparam logic [X_W-1:0]   H_LAST   = X_W'(H_TOTAL - 1);
  localparam logic [X_W-1:0]   H_VIS    = X_W'(H_ACTIVE);
  localparam logic [X_W-1:0]   HS_ON    = X_W'(H_ACTIVE + H_FP);
  localparam logic [X_W-1:0]   HS_OFF   = X_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [Y_W-1:0]   V_LAST   = Y_W'(V_TOTAL - 1);
  localparam logic [Y_W-1:0]   V_VIS    = Y_W'(V_ACTIVE);
  localparam logic [Y_W-1:0]   VS_ON    = Y_W'(V_ACTIVE + V_FP);
  localparam logic [Y_W-1:0]   VS_OFF   = Y_W'(V_ACTIVE + V_FP + V_SYNC);

  logic [DIV_W-1:0] div_cnt, div_nxt;
  logic [X_W-1:0]   h_cnt;
  logic [Y_W-1:0]   v_cnt;
  logic             hs_q, vs_q, blank_n_q;
  logic             in_vis;
  logic [2:0]       sync_dly;

  // ---------------- pixel clock divider ----------------
  always_comb begin
    div_nxt = div_cnt;
    if (enable) div_nxt = (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
  end

  // VGA_CLK is registered from the next count so it always equals
  // (div_cnt >= CLK_DIV/2) for the current div_cnt.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt <= '0;
      VGA_CLK <= 1'b0;
    end else begin
      div_cnt <= div_nxt;
      VGA_CLK <= (div_nxt >= DIV_HALF);
    end
  end

  assign pix_ce = enable && (div_cnt == DIV_LAST);

  // ---------------- raster counters ----------------
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (pix_ce) begin
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
      end else begin
        h_cnt <= h_cnt + 1'b1;
      end
    end
  end

  assign line_start  = pix_ce && (h_cnt == '0);
  assign frame_start = line_start && (v_cnt == '0);
  assign in_vis      = (h_cnt < H_VIS) && (v_cnt < V_VIS);

  // ---------------- output registers ----------------
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      x         <= '0;
      y         <= '0;
      active    <= 1'b0;
      hs_q      <= ~HS_POL;
      vs_q      <= ~VS_POL;
      blank_n_q <= 1'b0;
    end else if (pix_ce) begin
      x         <= h_cnt;
      y         <= v_cnt;
      active    <= in_vis;
      hs_q      <= ((h_cnt >= HS_ON) && (h_cnt < HS_OFF)) ? HS_POL : ~HS_POL;
      vs_q      <= ((v_cnt >= VS_ON) && (v_cnt < VS_OFF)) ? VS_POL : ~VS_POL;
      blank_n_q <= in_vis;
    end
  end

  sync_delay #(
    .DEPTH   (PIPE_LAT),
    .WIDTH   (3),
    .RST_VAL ({~HS_POL, ~VS_POL, 1'b0})
  ) u_sync_delay (
    .clk   (CLOCK_50),
    .rst_n (reset_n),
    .ce    (pix_ce),
    .din   ({hs_q, vs_q, blank_n_q}),
    .dout  (sync_dly)
  );

  // Disabling blanks and releases sync immediately, around the delay line,
  // which keeps its contents for the resume.
  assign VGA_HS      = enable ? sync_dly[2] : ~HS_POL;
  assign VGA_VS      = enable ? sync_dly[1] : ~VS_POL;
  assign VGA_BLANK_N = enable && sync_dly[0];
  assign VGA_SYNC_N  = 1'b0;

endmodule

// File: tb/tb_vga_timing_gen.sv
module tb_vga_timing_gen;

  localparam int NI = 4;
  // Instance configurations: 0 = default 640x480, 1 = 640x480 with 3-pixel
  // delay, 2 = 800x600 positive syncs, 3 = tiny raster to span many frames.
  localparam int HA [NI] = '{640, 640, 800, 8};
  localparam int HF [NI] = '{16,  16,  40,  2};
  localparam int HS [NI] = '{96,  96,  128, 3};
  localparam int HB [NI] = '{48,  48,  88,  2};
  localparam int VA [NI] = '{480, 480, 600, 4};
  localparam int VF [NI] = '{10,  10,  1,   1};
  localparam int VS [NI] = '{2,   2,   4,   2};
  localparam int VB [NI] = '{33,  33,  23,  1};
  localparam int HP [NI] = '{0,   0,   1,   1};
  localparam int VP [NI] = '{0,   0,   1,   0};
  localparam int DV [NI] = '{2,   2,   2,   3};
  localparam int LT [NI] = '{0,   3,   0,   2};
  localparam int N_CYC   = 7000;

  logic clk, reset_n, enable;
  logic ce [NI], ls [NI], fs [NI], act [NI], hs [NI], vs [NI], bn [NI], sn [NI], vclk [NI];
  logic [9:0]  x0, x1, y0, y1, y2;
  logic [10:0] x2;
  logic [3:0]  x3;
  logic [2:0]  y3;
  logic [31:0] ox [NI], oy [NI];

  assign ox[0] = 32'(x0); assign oy[0] = 32'(y0);
  assign ox[1] = 32'(x1); assign oy[1] = 32'(y1);
  assign ox[2] = 32'(x2); assign oy[2] = 32'(y2);
  assign ox[3] = 32'(x3); assign oy[3] = 32'(y3);

  int n_tests = 0;
  int n_fail  = 0;
  int ecnt;        // enabled CLOCK_50 cycles since reset release
  int p [NI];      // pixels issued since reset release

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  vga_timing_gen u0 (
    .CLOCK_50(clk), .reset_n(reset_n), .enable(enable), .pix_ce(ce[0]), .x(x0), .y(y0),
    .active(act[0]), .line_start(ls[0]), .frame_start(fs[0]), .VGA_HS(hs[0]), .VGA_VS(vs[0]),
    .VGA_BLANK_N(bn[0]), .VGA_SYNC_N(sn[0]), .VGA_CLK(vclk[0]));

  vga_timing_gen #(.PIPE_LAT(LT[1])) u1 (
    .CLOCK_50(clk), .reset_n(reset_n), .enable(enable), .pix_ce(ce[1]), .x(x1), .y(y1),
    .active(act[1]), .line_start(ls[1]), .frame_start(fs[1]), .VGA_HS(hs[1]), .VGA_VS(vs[1]),
    .VGA_BLANK_N(bn[1]), .VGA_SYNC_N(sn[1]), .VGA_CLK(vclk[1]));

  vga_timing_gen #(
    .H_ACTIVE(HA[2]), .H_FP(HF[2]), .H_SYNC(HS[2]), .H_BP(HB[2]),
    .V_ACTIVE(VA[2]), .V_FP(VF[2]), .V_SYNC(VS[2]), .V_BP(VB[2]),
    .HS_POL(1'b1), .VS_POL(1'b1), .CLK_DIV(DV[2]), .PIPE_LAT(LT[2]), .X_W(11), .Y_W(10)
  ) u2 (
    .CLOCK_50(clk), .reset_n(reset_n), .enable(enable), .pix_ce(ce[2]), .x(x2), .y(y2),
    .active(act[2]), .line_start(ls[2]), .frame_start(fs[2]), .VGA_HS(hs[2]), .VGA_VS(vs[2]),
    .VGA_BLANK_N(bn[2]), .VGA_SYNC_N(sn[2]), .VGA_CLK(vclk[2]));

  vga_timing_gen #(
    .H_ACTIVE(HA[3]), .H_FP(HF[3]), .H_SYNC(HS[3]), .H_BP(HB[3]),
    .V_ACTIVE(VA[3]), .V_FP(VF[3]), .V_SYNC(VS[3]), .V_BP(VB[3]),
    .HS_POL(1'b1), .VS_POL(1'b0), .CLK_DIV(DV[3]), .PIPE_LAT(LT[3]), .X_W(4), .Y_W(3)
  ) u3 (
    .CLOCK_50(clk), .reset_n(reset_n), .enable(enable), .pix_ce(ce[3]), .x(x3), .y(y3),
    .active(act[3]), .line_start(ls[3]), .frame_start(fs[3]), .VGA_HS(hs[3]), .VGA_VS(vs[3]),
    .VGA_BLANK_N(bn[3]), .VGA_SYNC_N(sn[3]), .VGA_CLK(vclk[3]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected outputs derived from pixel/cycle counts alone.
  task automatic check_all();
    for (int i = 0; i < NI; i++) begin
      int  ht, vt, d, k, q, h, v;
      logic e_ce, e_hs, e_vs, e_bn;
      ht   = HA[i] + HF[i] + HS[i] + HB[i];
      vt   = VA[i] + VF[i] + VS[i] + VB[i];
      d    = ecnt % DV[i];
      e_ce = enable && (d == DV[i] - 1);
      check($sformatf("pix_ce%0d", i), 32'(ce[i]), 32'(e_ce));
      check($sformatf("vga_clk%0d", i), 32'(vclk[i]), 32'(d >= DV[i] / 2));
      check($sformatf("line_start%0d", i), 32'(ls[i]), 32'(e_ce && (p[i] % ht == 0)));
      check($sformatf("frame_start%0d", i), 32'(fs[i]), 32'(e_ce && (p[i] % (ht * vt) == 0)));
      check($sformatf("sync_n%0d", i), 32'(sn[i]), 32'(0));
      if (p[i] == 0) begin
        check($sformatf("x%0d", i), ox[i], 32'(0));
        check($sformatf("y%0d", i), oy[i], 32'(0));
        check($sformatf("active%0d", i), 32'(act[i]), 32'(0));
      end else begin
        k = p[i] - 1;
        h = k % ht;
        v = (k / ht) % vt;
        check($sformatf("x%0d", i), ox[i], 32'(h));
        check($sformatf("y%0d", i), oy[i], 32'(v));
        check($sformatf("active%0d", i), 32'(act[i]), 32'((h < HA[i]) && (v < VA[i])));
      end
      q    = p[i] - 1 - LT[i];
      e_hs = !HP[i][0];
      e_vs = !VP[i][0];
      e_bn = 1'b0;
      if (enable && q >= 0) begin
        h = q % ht;
        v = (q / ht) % vt;
        if (h >= HA[i] + HF[i] && h < HA[i] + HF[i] + HS[i]) e_hs = HP[i][0];
        if (v >= VA[i] + VF[i] && v < VA[i] + VF[i] + VS[i]) e_vs = VP[i][0];
        e_bn = (h < HA[i]) && (v < VA[i]);
      end
      check($sformatf("hs%0d", i), 32'(hs[i]), 32'(e_hs));
      check($sformatf("vs%0d", i), 32'(vs[i]), 32'(e_vs));
      check($sformatf("blank_n%0d", i), 32'(bn[i]), 32'(e_bn));
    end
  endtask

  task automatic model_reset();
    ecnt = 0;
    for (int i = 0; i < NI; i++) p[i] = 0;
  endtask

  task automatic model_step();
    if (enable) begin
      for (int i = 0; i < NI; i++)
        if (ecnt % DV[i] == DV[i] - 1) p[i]++;
      ecnt++;
    end
  endtask

  initial begin
    int rst_at, rst_hold, drop_left;
    bit drop_done;
    rst_at    = 3500 + int'($urandom_range(0, 999));
    rst_hold  = 0;
    drop_left = 0;
    drop_done = 1'b0;
    reset_n   = 1'b0;
    enable    = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    for (int cyc = 0; cyc < N_CYC; cyc++) begin
      if (cyc == 0 || cyc == rst_at) begin
        // Async assertion: outputs must collapse before any clock edge.
        reset_n  = 1'b0;
        rst_hold = 3;
        #1;
        model_reset();
        check_all();
      end else if (rst_hold > 0) begin
        rst_hold--;
        if (rst_hold == 0) reset_n = 1'b1;
      end

      if (drop_left > 0) begin
        enable = 1'b0;
        drop_left--;
      end else begin
        enable = 1'b1;
        if (!drop_done && reset_n && p[0] == 101) begin
          enable    = 1'b0;
          drop_left = 36;
          drop_done = 1'b1;
        end else if ($urandom_range(0, 299) == 0) begin
          enable    = 1'b0;
          drop_left = int'($urandom_range(0, 39));
        end
      end

      @(negedge clk);
      check_all();
      if (reset_n) model_step();
      @(posedge clk);
      #1;
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
